// File: rtl/demux2_reg.sv
// ============================================================================
// Module   : demux2_reg
// Purpose  : 1-to-2 demultiplexer with a registered valid/ready slot per output.
//            Optional macro DEMUX2_REG_COUNT_EN adds per-output 16-bit transfer counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD
`define WORD 64
`endif

module demux2_reg #(
  parameter int SIZE = `WORD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_sel,
  input  logic [SIZE-1:0] in_data,
  output logic            in_ready,
  output logic            out0_valid,
  output logic [SIZE-1:0] out0_data,
  input  logic            out0_ready,
  output logic            out1_valid,
  output logic [SIZE-1:0] out1_data,
  input  logic            out1_ready
`ifdef DEMUX2_REG_COUNT_EN
  ,
  output logic [15:0]     cnt0,
  output logic [15:0]     cnt1
`endif
);

  logic [1:0]      w_valid;
  logic [1:0]      w_out_ready;
  logic [1:0]      w_pop;
  logic [1:0]      w_load;
  logic [SIZE-1:0] w_data [2];
  logic            w_push;

  assign w_out_ready = {out1_ready, out0_ready};

  // Ready depends only on the selected slot, never on in_valid.
  assign in_ready = ~w_valid[in_sel] | w_out_ready[in_sel];
  assign w_push   = in_valid & in_ready;

  generate
    for (genvar k = 0; k < 2; k++) begin : g_slot
      logic            r_v;
      logic [SIZE-1:0] r_d;

      assign w_pop[k]  = r_v & w_out_ready[k];
      assign w_load[k] = w_push & (in_sel == 1'(k));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v <= 1'b0;
          r_d <= '0;
        end else if (w_load[k]) begin
          r_v <= 1'b1;
          r_d <= in_data;
        end else if (w_pop[k]) begin
          r_v <= 1'b0;
        end
      end

      assign w_valid[k] = r_v;
      assign w_data[k]  = r_d;
    end
  endgenerate

  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out0_data  = w_data[0];
  assign out1_data  = w_data[1];

`ifdef DEMUX2_REG_COUNT_EN
  logic [15:0] w_cnt [2];

  generate
    for (genvar k = 0; k < 2; k++) begin : g_cnt
      logic [15:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (w_pop[k]) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end

      assign w_cnt[k] = r_cnt;
    end
  endgenerate

  assign cnt0 = w_cnt[0];
  assign cnt1 = w_cnt[1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux2_reg.sv
// ============================================================================
// Module   : tb_demux2_reg
// Purpose  : Self-checking bench for demux2_reg (covers DEMUX2_REG_COUNT_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux2_reg;

  localparam int SIZE = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_sel;
  logic [SIZE-1:0] in_data;
  logic            in_ready;
  logic            out0_valid, out1_valid;
  logic [SIZE-1:0] out0_data, out1_data;
  logic            out0_ready, out1_ready;
`ifdef DEMUX2_REG_COUNT_EN
  logic [15:0]     cnt0, cnt1;
`endif

  int total = 0;
  int bad   = 0;

  demux2_reg #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready)
`ifdef DEMUX2_REG_COUNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: each output is a queue of capacity one; counters count pops.
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [15:0] m_cnt0, m_cnt1;

  function automatic bit m_ready(input logic sel);
    if (sel) return (q1.size() == 0) || out1_ready;
    return (q0.size() == 0) || out0_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_cnt0 = 16'd0;
      m_cnt1 = 16'd0;
    end else begin
      bit acc;
      acc = in_valid && m_ready(in_sel);
      if (out0_ready && q0.size() > 0) begin
        void'(q0.pop_front());
        m_cnt0 = m_cnt0 + 16'd1;
      end
      if (out1_ready && q1.size() > 0) begin
        void'(q1.pop_front());
        m_cnt1 = m_cnt1 + 16'd1;
      end
      if (acc) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_in_ready", {63'd0, in_ready}, {63'd0, m_ready(in_sel)});
    chk("cyc_out0_valid", {63'd0, out0_valid}, {63'd0, q0.size() > 0});
    chk("cyc_out1_valid", {63'd0, out1_valid}, {63'd0, q1.size() > 0});
    if (q0.size() > 0) chk("cyc_out0_data", out0_data, q0[0]);
    if (q1.size() > 0) chk("cyc_out1_data", out1_data, q1[0]);
`ifdef DEMUX2_REG_COUNT_EN
    chk("cyc_cnt0", {48'd0, cnt0}, {48'd0, m_cnt0});
    chk("cyc_cnt1", {48'd0, cnt1}, {48'd0, m_cnt1});
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    #2;
    chk("rst_out0_valid", {63'd0, out0_valid}, 64'd0);
    chk("rst_out1_valid", {63'd0, out1_valid}, 64'd0);
    chk("rst_out0_data", out0_data, 64'd0);
    chk("rst_out1_data", out1_data, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // basic route to out0
    in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h1234;
    #1 chk("basic_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0; in_sel = 1'b1;
    #1;
    chk("basic_out0_valid", {63'd0, out0_valid}, 64'd1);
    chk("basic_out0_data", out0_data, 64'h1234);
    chk("basic_out1_valid", {63'd0, out1_valid}, 64'd0);
    out0_ready = 1'b1;
    tick();
    out0_ready = 1'b0;

    // backpressure on out1
    in_valid = 1'b1; in_sel = 1'b1; in_data = 64'hA;
    tick();
    in_data = 64'hB;
    #1 chk("bp_in_ready_stalled", {63'd0, in_ready}, 64'd0);
    tick();
    chk("bp_out1_data_held", out1_data, 64'hA);
    chk("bp_out1_valid_held", {63'd0, out1_valid}, 64'd1);
    out1_ready = 1'b1;
    #1 chk("bp_in_ready_released", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0; out1_ready = 1'b0;
    #1;
    chk("bp_out1_data_new", out1_data, 64'hB);
    chk("bp_out1_valid_new", {63'd0, out1_valid}, 64'd1);

    // independence: out1 stalled, out0 still accepts
    in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hC;
    #1 chk("ind_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("ind_out0_data", out0_data, 64'hC);
    chk("ind_out1_data", out1_data, 64'hB);
    chk("ind_out1_valid", {63'd0, out1_valid}, 64'd1);
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    out1_ready = 1'b0;

    // streaming 8 words through out0 with ready held high
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 1'b0; in_data = 64'(100 + i);
      #1 chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      chk("stream_out0_data", out0_data, 64'(100 + i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", {63'd0, out0_valid}, 64'd0);
    out0_ready = 1'b0;

    // reset mid-operation with both slots full
    in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h55;
    tick();
    in_sel = 1'b1; in_data = 64'h66;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out0_valid", {63'd0, out0_valid}, 64'd0);
    chk("mid_rst_out1_valid", {63'd0, out1_valid}, 64'd0);
    chk("mid_rst_out0_data", out0_data, 64'd0);
    chk("mid_rst_out1_data", out1_data, 64'd0);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hDEAD;
    #1 chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("mid_rst_no_capture", {63'd0, out0_valid}, 64'd0);
    in_valid = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_out0_valid", {63'd0, out0_valid}, 64'd0);
    chk("post_rst_out1_valid", {63'd0, out1_valid}, 64'd0);

`ifdef DEMUX2_REG_COUNT_EN
    // 65537 words through out0: counter wraps once and lands on 1
    out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      in_data = 64'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("cnt0_wrap", {48'd0, cnt0}, 64'd1);
    chk("cnt1_idle", {48'd0, cnt1}, 64'd0);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
